// File: rtl/ext_bus_arbiter_if.sv
// ext_bus_arbiter_if: master request/response and external bus signals of the arbiter
interface ext_bus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [11:0] m0_addr;
  logic [3:0]  m0_wdata;
  logic [3:0]  m0_rdata;
  logic        m0_ack;
  logic        m1_req;
  logic        m1_we;
  logic [11:0] m1_addr;
  logic [3:0]  m1_wdata;
  logic [3:0]  m1_rdata;
  logic        m1_ack;
  logic [11:0] bus_addr;
  logic [3:0]  bus_data_out;
  logic [3:0]  bus_data_in;
  logic        bus_rw;
  logic [1:0]  owner;
  logic        busy;
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, bus_data_in,
    output m0_rdata, m0_ack, m1_rdata, m1_ack, bus_addr, bus_data_out, bus_rw, owner, busy
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, bus_data_in,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack, bus_addr, bus_data_out, bus_rw, owner, busy
  );
endinterface

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: round-robin sharing of the external nibble bus with setup/hold/ack sequencing
module ext_bus_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input logic clk,
  input logic rst,
  ext_bus_arbiter_if.slave bus
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  typedef enum logic [1:0] {IDLE, SETUP, HOLD, ACK} state_t;
  state_t      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [3:0]  wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  r0_q, r0_d;
  logic [3:0]  r1_q, r1_d;
  logic        rw_q, rw_d;
  logic        last_q, last_d;
  logic [1:0]  owner_q, owner_d;
  logic        gnt0, gnt1, sample;
  // state and bus register bank; last_grant resets to master 1 so master 0 wins first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      rw_q    <= 1'b0;
      last_q  <= 1'b1;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      rw_q    <= rw_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end
  // arbitration, transfer sequencing and read-data capture on the cycle before ACK
  always_comb begin
    gnt1    = bus.m1_req & (~bus.m0_req | ~last_q);
    gnt0    = bus.m0_req & ~gnt1;
    sample  = (state_q == HOLD && cnt_q == 4'd1) || (state_q == SETUP && WS == 4'd0);
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    last_d  = last_q;
    owner_d = owner_q;
    r0_d    = (sample && owner_q[0]) ? bus.bus_data_in : r0_q;
    r1_d    = (sample && owner_q[1]) ? bus.bus_data_in : r1_q;
    case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          state_d = SETUP;
          addr_d  = gnt1 ? bus.m1_addr : bus.m0_addr;
          rw_d    = gnt1 ? bus.m1_we : bus.m0_we;
          wdata_d = rw_d ? (gnt1 ? bus.m1_wdata : bus.m0_wdata) : 4'd0;
          owner_d = {gnt1, gnt0};
          last_d  = gnt1;
        end
      end
      SETUP: begin
        cnt_d   = WS;
        state_d = (WS == 4'd0) ? ACK : HOLD;
        rw_d    = (WS == 4'd0) ? 1'b0 : rw_q;
      end
      HOLD: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? ACK : HOLD;
        rw_d    = (cnt_q == 4'd1) ? 1'b0 : rw_q;
      end
      ACK: begin
        state_d = IDLE;
        owner_d = 2'b00;
      end
    endcase
  end
  assign bus.bus_addr     = addr_q;
  assign bus.bus_data_out = wdata_q;
  assign bus.bus_rw       = rw_q;
  assign bus.owner        = owner_q;
  assign bus.busy         = state_q != IDLE;
  assign bus.m0_ack       = (state_q == ACK) && owner_q[0];
  assign bus.m1_ack       = (state_q == ACK) && owner_q[1];
  assign bus.m0_rdata     = r0_q;
  assign bus.m1_rdata     = r1_q;
endmodule

// File: doc/ext_bus_arbiter.md
Name: ext_bus_arbiter

Overview:
- Sequences and shares the single external memory bus (12-bit address, 4-bit bidirectional data nibble, read/write direction line) between two requesters.
- Master 0 is the CPU core; master 1 is the debug/program-loader port.
- Runs every transfer as a fixed setup/hold/acknowledge sequence with programmable wait states.
- Arbitrates round-robin. Sits between the masters and the top-level pad mapping (address on uo_out/uio_out[7:4], data on uio[3:0], direction driving the low-nibble output enables).

Parameters:
- WAIT_STATES, 1, number of HOLD cycles the address/data are held before read data is sampled (legal 0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- m0_req  in  1  master 0 transfer request, level, held until m0_ack
- m0_we  in  1  master 0: 1=write, 0=read
- m0_addr  in  12  master 0 address
- m0_wdata  in  4  master 0 write nibble
- m0_rdata  out  4  master 0 read nibble, valid while m0_ack=1
- m0_ack  out  1  master 0 completion pulse, 1 cycle
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same as master 0
- bus_addr  out  12  external address
- bus_data_out  out  4  external write nibble
- bus_data_in  in  4  external read nibble
- bus_rw  out  1  1=write (data pads driven), 0=read/released
- owner  out  2  one-hot current bus owner ({m1,m0}); 00 when idle
- busy  out  1  1 in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE; bus_addr=0, bus_data_out=0, bus_rw=0.
  - m0/m1_ack=0, m0/m1_rdata=0, owner=00, busy=0.
  - last_grant=1, so master 0 wins the first contention.
- Reset mid-transfer aborts immediately to the reset values. No ack is issued for the aborted transfer.
- FSM: IDLE -> SETUP -> HOLD (WAIT_STATES cycles; skipped if 0) -> ACK -> IDLE.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the master that is not last_grant.
  - On grant, register addr, we and wdata of the winner into bus_addr, bus_rw and bus_data_out (bus_data_out=0 for reads). Set owner and last_grant, go to SETUP.
  - No req: stay. bus_addr holds its last value; bus_rw=0.
- SETUP: bus outputs stable. Load the 4-bit wait counter with WAIT_STATES. Go to HOLD, or to ACK if WAIT_STATES=0.
- HOLD: decrement the counter each cycle. Leave for ACK on the cycle the counter reaches 1.
- Read sampling: bus_data_in is registered into the owner's rdata on the final cycle before ACK (last HOLD cycle, or SETUP when WAIT_STATES=0). The non-owner's rdata is unchanged.
- ACK:
  - Owner's ack=1 for exactly this cycle; bus_rw=0 (pads released). owner still valid.
  - Next state is IDLE; owner returns to 00 there.
- Latency: req high in IDLE at cycle 0 -> ack high in cycle 2+WAIT_STATES. Minimum gap between grants is one IDLE cycle, so throughput is one transfer per 3+WAIT_STATES cycles.
- Arbitration is sampled only in IDLE. Requests arriving mid-transfer wait; the granted transfer is never pre-empted.
- A req dropped before its ack: the transfer still completes, the ack is still pulsed, the bus cycle is not cancelled.
- A master may keep req high after ack to issue its next transfer with new addr/we/wdata. It is re-arbitrated in IDLE, so a contending master is served first (no starvation).
- Write: bus_addr, bus_data_out and bus_rw=1 are constant from SETUP through the last HOLD cycle. Address is never changed while bus_rw=1.
- At most one ack is high in any cycle; ack is high only for the owner.

Test Plan:
- WAIT_STATES=1, m0 read addr 0x3A5, bus_data_in=0xC -> bus_addr=0x3A5, bus_rw=0 in cycles 1-2. m0_ack=1, m0_rdata=0xC in cycle 3 only. m1_rdata unchanged.
- WAIT_STATES=1, m1 write addr 0xFFF, data 0x7 -> bus_rw=1, bus_data_out=0x7 in cycles 1-2. bus_rw=0 and m1_ack=1 in cycle 3. owner=10 in cycles 1-3.
- Both req in the same cycle after reset, both held -> m0 served first (ack cycle 3), m1 granted in the next IDLE (ack cycle 7); strict alternation thereafter.
- WAIT_STATES=0 and WAIT_STATES=15 builds, single read -> ack at cycle 2 and cycle 17 respectively. Data is sampled on the cycle before ack.
- rst=1 during HOLD of a write -> next cycle bus_rw=0, owner=00, no ack. A subsequent request runs normally with master 0 priority.
- m0 drops req in SETUP -> m0_ack still pulses at cycle 2+WAIT_STATES; a pending m1 req is granted in the following IDLE.
